fetch_queue: RTL
================

// Module: fetch_queue
// PURPOSE
//  Instruction fetch stage directly upstream of the single-cycle R-type/LW datapath.
//  Owns the PC and issues word reads to a synchronous instruction memory.
//  Buffers returned words with their PCs in a DEPTH-entry FIFO.
//  Hands them to decode over a valid/ready handshake; a redirect flushes all fetch state.
// PARAMETERS
//  DEPTH      4             FIFO entries (power of 2, >=2); also max outstanding reads
//  RESET_PC   32'h0000_0000 PC loaded on reset (byte address, word aligned)
// PORTS
//  clk          in   1   rising-edge clock
//  reset        in   1   synchronous, active-low reset (0 = reset)
//  imem_req     out  1   read request this cycle
//  imem_addr    out  32  byte address of request; memory indexes addr[31:2]
//  imem_rvalid  in   1   read data valid; responses in order, latency >=1 cycle
//  imem_rdata   in   32  instruction word
//  redirect     in   1   flush and restart fetch at redirect_pc
//  redirect_pc  in   32  new PC; bits [1:0] ignored (forced 0)
//  instr_valid  out  1   FIFO head valid
//  instr_ready  in   1   decode accepts head
//  instr        out  32  head instruction word
//  instr_pc     out  32  head PC
//  q_count      out  $clog2(DEPTH)+1  FIFO occupancy
// BEHAVIOUR
//  - Reset (sampled at posedge, reset==0): pc=RESET_PC, FIFO empty, outstanding=0, drop=0.
//    Outputs: imem_req=0, instr_valid=0, q_count=0; instr/instr_pc hold last value.
//    Reset mid-flight: all pending responses are forgotten; rvalid in the first cycle after reset is ignored.
//  - Issue: imem_req=1 iff reset==1 && !redirect && (q_count + outstanding) < DEPTH.
//    imem_addr=pc; on issue pc<=pc+4 (wraps modulo 2^32) and outstanding+1.
//  - Response: imem_rvalid with drop==0 pushes {rdata, pc_of_request} and outstanding-1.
//    Request PCs are held in a DEPTH-deep tag FIFO.
//    Response with drop>0 is discarded: drop-1, outstanding-1. The credit check guarantees the FIFO never overflows.
//  - Pop: instr_valid && instr_ready pops the head. instr/instr_pc are combinational from the FIFO head.
//  - Same-cycle push+pop: q_count unchanged.
//    Pop on empty is impossible, since instr_valid=0 then. Push when full cannot occur; assertion required.
//  - Latency: request at cycle N, rvalid at N+1 -> instr_valid at N+2 (registered FIFO write).
//  - Redirect (highest priority):
//    - pc <= {redirect_pc[31:2],2'b00}; FIFO and tag FIFO cleared; no push, no pop that cycle.
//    - drop <= outstanding minus any response arriving that same cycle; no request issued that cycle.
//    - Redirect while drop>0 accumulates the same way.
//  - FSM states:
//    - RUN: normal; enter after reset or once drop reaches 0.
//    - FLUSH: drop>0; issue still allowed for new PCs, and their responses queue behind the dropped ones.
//  - Accounting: q_count + outstanding <= DEPTH at all times; outstanding counter is $clog2(DEPTH)+1 bits.
// CONFIGURATION
//  - FETCH_STATS_EN defined: adds out ports stall_cycles[31:0] and flush_count[15:0].
//    - stall_cycles counts cycles with imem_req==0 && reset==1 && !redirect.
//    - flush_count counts redirect pulses.
//    - Both saturate at all-ones and clear on reset.
//  - FETCH_STATS_EN undefined: ports and counters absent; behaviour otherwise identical.
// TESTING
//  1. Reset held 3 cycles, then released; 1-cycle memory, instr_ready=1.
//     -> imem_addr 0,4,8,...; instr_pc 0 at release+2; one instr per cycle.
//  2. instr_ready=0 after release.
//     -> exactly 4 requests (0,4,8,C); q_count=4; imem_req=0 thereafter.
//     Raise ready -> pops 0,4,8,C in order, with fetch refilling.
//  3. Memory latency 3, ready=1.
//     -> max 4 outstanding; words returned for addrs 0..0x18 match the loaded program in order.
//  4. Redirect to 32'h0000_0042 with 2 reads outstanding.
//     -> next imem_addr=0x40; the 2 stale responses dropped; first instr_pc=0x40.
//  5. Redirect and instr_ready same cycle with FIFO full -> no pop; q_count=0 next cycle.
//  6. reset=0 while 3 reads outstanding, released next cycle.
//     -> late rvalids ignored; fetch restarts at RESET_PC.
//     With FETCH_STATS_EN, flush_count=0 after reset.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: PC owner, instruction memory requester and in-order fetch FIFO with redirect flush; FETCH_STATS_EN adds stall/flush counters
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic clk,
  input  logic reset,
  output logic imem_req,
  output logic [31:0] imem_addr,
  input  logic imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic redirect,
  input  logic [31:0] redirect_pc,
  output logic instr_valid,
  input  logic instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [$clog2(DEPTH):0] q_count
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_count
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int W = AW + 1;
  typedef enum logic {RUN, FLUSH} state_t;
  state_t state, state_next;
  logic [31:0] pc;
  logic [31:0] q_instr [DEPTH];
  logic [31:0] q_pc [DEPTH];
  logic [31:0] tag_pc [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, tag_rd, tag_wr;
  logic [W-1:0] count, outstanding, drop, drop_next;
  logic resp, push, pop;
  // a response with nothing outstanding is stale from before reset
  assign resp = imem_rvalid && outstanding != '0;
  assign push = resp && state == RUN && !redirect;
  assign pop = instr_valid && instr_ready && !redirect;
  assign imem_req = reset && !redirect && ({1'b0, count} + {1'b0, outstanding}) < (W + 1)'(DEPTH);
  assign imem_addr = pc;
  assign instr_valid = reset && count != '0;
  assign instr = q_instr[rd_ptr];
  assign instr_pc = q_pc[rd_ptr];
  assign q_count = count;
  always_comb begin
    drop_next = redirect ? outstanding - W'(resp) : drop - W'(resp && state == FLUSH);
    state_next = drop_next != '0 ? FLUSH : RUN;
  end
  // flushes move the write pointers back to the read pointers so the head word holds
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc <= RESET_PC;
      wr_ptr <= rd_ptr;
      tag_wr <= tag_rd;
      count <= '0;
      outstanding <= '0;
      drop <= '0;
      state <= RUN;
    end else begin
      outstanding <= outstanding + W'(imem_req) - W'(resp);
      drop <= drop_next;
      state <= state_next;
      if (redirect) begin
        pc <= redirect_pc & ~32'h3;
        wr_ptr <= rd_ptr;
        tag_wr <= tag_rd;
        count <= '0;
      end else begin
        if (imem_req) begin
          pc <= pc + 32'd4;
          tag_pc[tag_wr] <= pc;
          tag_wr <= tag_wr + 1'b1;
        end
        if (push) begin
          q_instr[wr_ptr] <= imem_rdata;
          q_pc[wr_ptr] <= tag_pc[tag_rd];
          wr_ptr <= wr_ptr + 1'b1;
          tag_rd <= tag_rd + 1'b1;
        end
        if (pop)
          rd_ptr <= rd_ptr + 1'b1;
        count <= count + W'(push) - W'(pop);
      end
    end
  end
  always_ff @(posedge clk)
    if (reset && push)
      assert (count != W'(DEPTH));
`ifdef FETCH_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cycles <= '0;
      flush_count <= '0;
    end else begin
      if (!imem_req && !redirect && stall_cycles != '1)
        stall_cycles <= stall_cycles + 1'b1;
      if (redirect && flush_count != '1)
        flush_count <= flush_count + 1'b1;
    end
  end
`endif
endmodule
